// File: rtl/framebuffer_reader.sv
// Reads one RGB565 frame out of a banked framebuffer RAM and streams it in raster order
// over valid/ready. RAM read latency is hidden behind a small output FIFO whose credit
// (entries held + reads in flight) gates read issue, so backpressure never drops a pixel.
//
// Ports:
//   clk_i           single clock
//   rst_i           synchronous, active-high reset
//   frame_start_i   1-cycle pulse: begin reading a frame
//   bank_select_i   bank to read, sampled with an accepted frame_start_i
//   ram_addr_o      RAM read address (registered)
//   ram_read_o      RAM read strobe (registered); ram_data_i valid one cycle later
//   ram_data_i      RAM read data
//   pixel_data_o    FIFO head pixel
//   pixel_valid_o   FIFO non-empty
//   pixel_ready_i   consumer accepts when pixel_valid_o && pixel_ready_i
//   pixel_last_o    head pixel is last of its line
//   frame_last_o    head pixel is last of the frame
//   busy_o          reader not idle (registered)
//   overrun_o       1-cycle pulse: frame_start_i while busy (registered)
module framebuffer_reader #(
  parameter int unsigned RamAddrWidth = 32,
  parameter int unsigned RamDataWidth = 16,
  parameter int unsigned ImageWidth   = 80,
  parameter int unsigned ImageHeight  = 48,
  parameter int unsigned FifoDepth    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    frame_start_i,
  input  logic                    bank_select_i,
  output logic [RamAddrWidth-1:0] ram_addr_o,
  output logic                    ram_read_o,
  input  logic [RamDataWidth-1:0] ram_data_i,
  output logic [RamDataWidth-1:0] pixel_data_o,
  output logic                    pixel_valid_o,
  input  logic                    pixel_ready_i,
  output logic                    pixel_last_o,
  output logic                    frame_last_o,
  output logic                    busy_o,
  output logic                    overrun_o
);

  localparam int unsigned ImageSize = ImageWidth * ImageHeight;
  localparam int unsigned IdxW      = $clog2(ImageSize);
  localparam int unsigned XW        = $clog2(ImageWidth);
  localparam int unsigned PtrW      = $clog2(FifoDepth);
  localparam int unsigned CntW      = PtrW + 1;
  localparam int unsigned OccW      = CntW + 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [RamAddrWidth-1:0] base_q, base_d;
  logic [IdxW-1:0]         rd_idx_q, rd_idx_d;
  logic [XW-1:0]           x_q, x_d;

  // Read stage: request on the RAM port this cycle, with its tag.
  logic [RamAddrWidth-1:0] ram_addr_q, ram_addr_d;
  logic                    ram_read_q, ram_read_d;
  logic                    tag_line_q, tag_line_d;
  logic                    tag_frame_q, tag_frame_d;
  // Return stage: ram_data_i valid this cycle, pushed at the next edge.
  logic                    rvalid_q;
  logic                    rtag_line_q;
  logic                    rtag_frame_q;

  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic [RamDataWidth-1:0] mem_data_q  [FifoDepth];
  logic                    mem_line_q  [FifoDepth];
  logic                    mem_frame_q [FifoDepth];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q;

  logic                    push, pop, credit_ok, issue, head_frame;
  logic [OccW-1:0]         occupancy;
  logic [IdxW-1:0]         idx_cur;
  logic [XW-1:0]           x_cur;

  assign push       = rvalid_q;
  assign head_frame = mem_frame_q[rd_ptr_q];
  assign pop        = pixel_valid_o && pixel_ready_i;

  // Every read already issued owns a FIFO slot, so the FIFO can never overflow.
  assign occupancy = OccW'(count_q) + OccW'(ram_read_q) + OccW'(rvalid_q);
  assign credit_ok = occupancy < OccW'(FifoDepth);

  // Next-state logic. The first read issues straight out of idle so the strobe appears
  // the cycle after frame_start_i is sampled.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_cur = rd_idx_q;
    x_cur   = x_q;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start_i) begin
          state_d = StRead;
          base_d  = bank_select_i ? RamAddrWidth'(ImageSize) : '0;
          idx_cur = '0;
          x_cur   = '0;
          issue   = credit_ok;
        end
      end
      StRead:  issue = credit_ok;
      StDrain: if (pop && head_frame) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    rd_idx_d = idx_cur;
    x_d      = x_cur;
    if (issue) begin
      rd_idx_d = idx_cur + IdxW'(1);
      x_d      = (x_cur == XW'(ImageWidth - 1)) ? '0 : x_cur + XW'(1);
      if (idx_cur == IdxW'(ImageSize - 1)) state_d = StDrain;
    end
  end

  // Output logic feeding the registered outputs.
  always_comb begin
    ram_read_d  = issue;
    ram_addr_d  = issue ? base_d + RamAddrWidth'(idx_cur) : ram_addr_q;
    tag_line_d  = issue && (x_cur == XW'(ImageWidth - 1));
    tag_frame_d = issue && (idx_cur == IdxW'(ImageSize - 1));
    busy_d      = (state_d != StIdle);
    overrun_d   = frame_start_i && (state_q != StIdle);
  end

  // State register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      base_q       <= '0;
      rd_idx_q     <= '0;
      x_q          <= '0;
      ram_addr_q   <= '0;
      ram_read_q   <= 1'b0;
      tag_line_q   <= 1'b0;
      tag_frame_q  <= 1'b0;
      rvalid_q     <= 1'b0;
      rtag_line_q  <= 1'b0;
      rtag_frame_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      rd_idx_q     <= rd_idx_d;
      x_q          <= x_d;
      ram_addr_q   <= ram_addr_d;
      ram_read_q   <= ram_read_d;
      tag_line_q   <= tag_line_d;
      tag_frame_q  <= tag_frame_d;
      rvalid_q     <= ram_read_q;
      rtag_line_q  <= tag_line_q;
      rtag_frame_q <= tag_frame_q;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // Output FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(FifoDepth); i++) begin
        mem_data_q[i]  <= '0;
        mem_line_q[i]  <= 1'b0;
        mem_frame_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data_q[wr_ptr_q]  <= ram_data_i;
        mem_line_q[wr_ptr_q]  <= rtag_line_q;
        mem_frame_q[wr_ptr_q] <= rtag_frame_q;
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      assert (count_q < CntW'(FifoDepth) || pop)
        else $error("framebuffer_reader: push into full FIFO");
    end
  end

  assign ram_addr_o    = ram_addr_q;
  assign ram_read_o    = ram_read_q;
  assign busy_o        = busy_q;
  assign overrun_o     = overrun_q;
  assign pixel_valid_o = (count_q != '0);
  assign pixel_data_o  = mem_data_q[rd_ptr_q];
  assign pixel_last_o  = pixel_valid_o && mem_line_q[rd_ptr_q];
  assign frame_last_o  = pixel_valid_o && head_frame;

endmodule

// File: tb/tb_framebuffer_reader.sv
module tb_framebuffer_reader;

  localparam int W     = 80;
  localparam int H     = 48;
  localparam int Size  = W * H;
  localparam int Depth = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        frame_start_i = 1'b0;
  logic        bank_select_i = 1'b0;
  logic [31:0] ram_addr_o;
  logic        ram_read_o;
  logic [15:0] ram_data_i = 16'hdead;
  logic [15:0] pixel_data_o;
  logic        pixel_valid_o;
  logic        pixel_ready_i = 1'b0;
  logic        pixel_last_o;
  logic        frame_last_o;
  logic        busy_o;
  logic        overrun_o;

  framebuffer_reader #(
    .RamAddrWidth(32),
    .RamDataWidth(16),
    .ImageWidth  (W),
    .ImageHeight (H),
    .FifoDepth   (Depth)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .frame_start_i(frame_start_i),
    .bank_select_i(bank_select_i),
    .ram_addr_o   (ram_addr_o),
    .ram_read_o   (ram_read_o),
    .ram_data_i   (ram_data_i),
    .pixel_data_o (pixel_data_o),
    .pixel_valid_o(pixel_valid_o),
    .pixel_ready_i(pixel_ready_i),
    .pixel_last_o (pixel_last_o),
    .frame_last_o (frame_last_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: data equals address, valid exactly one cycle after the strobe.
  always @(posedge clk_i) begin
    if (ram_read_o) ram_data_i <= ram_addr_o[15:0];
    else            ram_data_i <= 16'hdead;
  end

  int checks = 0;
  int errors = 0;
  int exp_base, n_issued, n_accepted;
  int cyc = 0;
  int first_acc, last_acc, s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic reset_model(input int base);
    exp_base   = base;
    n_issued   = 0;
    n_accepted = 0;
  endtask

  // One clock: drive inputs at the falling edge, then check what the DUT shows there.
  // Expected stream: pixel i of the frame is RAM word base+i.
  task automatic step(input logic rdy, input logic fs, input logic bs, input logic rs);
    @(negedge clk_i);
    cyc++;
    rst_i         = rs;
    frame_start_i = fs;
    bank_select_i = bs;
    pixel_ready_i = rdy;
    if (ram_read_o) begin
      chk("ram_addr", ram_addr_o, 32'(exp_base + n_issued));
      n_issued++;
    end
    chk("outstanding_le_depth", 32'((n_issued - n_accepted) <= Depth), 32'd1);
    if (pixel_valid_o && rdy && !rs) begin
      if (n_accepted == 0) first_acc = cyc;
      if (n_accepted == Size - 1) last_acc = cyc;
      chk("pixel_data", 32'(pixel_data_o), 32'(exp_base + n_accepted));
      chk("pixel_last", 32'(pixel_last_o), 32'((n_accepted % W) == W - 1));
      chk("frame_last", 32'(frame_last_o), 32'(n_accepted == Size - 1));
      n_accepted++;
    end
  endtask

  task automatic run_until(input int pct, input int target, input int limit);
    int guard = 0;
    while (n_accepted < target && guard < limit) begin
      step(int'($urandom_range(0, 99)) < pct, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    if (n_accepted < target) chk("timeout", 32'(n_accepted), 32'(target));
  endtask

  task automatic frame_done();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("busy_falls", 32'(busy_o), 32'd0);
    chk("reads_once_each", 32'(n_issued), 32'(Size));
    chk("fifo_empty_at_end", 32'(pixel_valid_o), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ram_addr"}, ram_addr_o, 32'd0);
    chk({tag, "_ram_read"}, 32'(ram_read_o), 32'd0);
    chk({tag, "_pixel_data"}, 32'(pixel_data_o), 32'd0);
    chk({tag, "_pixel_valid"}, 32'(pixel_valid_o), 32'd0);
    chk({tag, "_pixel_last"}, 32'(pixel_last_o), 32'd0);
    chk({tag, "_frame_last"}, 32'(frame_last_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun_o), 32'd0);
  endtask

  initial begin
    // Power-on reset.
    reset_model(0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_zero("reset");
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_zero("idle");

    // Bank 0, ready held high: full rate, fixed latency.
    reset_model(0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    s = cyc;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("first_read_latency", 32'(n_issued), 32'd1);
    chk("busy_after_start", 32'(busy_o), 32'd1);
    run_until(100, Size, 5000);
    chk("first_pixel_latency", 32'(first_acc - s), 32'd3);
    chk("frame_cycles", 32'(last_acc - s), 32'(Size + 2));
    frame_done();

    // Bank 1.
    reset_model(Size);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run_until(100, Size, 5000);
    frame_done();

    // Random backpressure with a long stall in the middle.
    reset_model(0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_until(50, 300, 3000);
    repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_no_read", 32'(ram_read_o), 32'd0);
    chk("stall_outstanding", 32'(n_issued - n_accepted), 32'(Depth));
    chk("stall_valid", 32'(pixel_valid_o), 32'd1);
    run_until(50, Size, 20000);
    frame_done();

    // frame_start while busy with the other bank selected.
    reset_model(0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_until(100, 1000, 2000);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("overrun_pulse", 32'(overrun_o), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("overrun_one_cycle", 32'(overrun_o), 32'd0);
    chk("busy_during_overrun", 32'(busy_o), 32'd1);
    run_until(100, Size, 5000);
    frame_done();

    // Reset held 3 cycles mid-stream.
    reset_model(Size);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run_until(100, 200, 1000);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk_zero("midrst_a");
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk_zero("midrst_b");
    reset_model(0);
    repeat (5) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_rst_no_read", 32'(ram_read_o), 32'd0);
      chk("post_rst_no_valid", 32'(pixel_valid_o), 32'd0);
    end

    // Reset at pixel 500, then a fresh bank-0 frame must start from pixel 0.
    reset_model(0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_until(100, 500, 2000);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst500_valid", 32'(pixel_valid_o), 32'd0);
    chk("rst500_busy", 32'(busy_o), 32'd0);
    reset_model(0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_until(50, Size, 20000);
    frame_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
